// File: rtl/spi_master_tx.sv
// SPI mode-0 master: serialises one DATA_W word per transfer MSB-first on mosi, samples miso into rx_data.
// Latency: CS_SETUP + 2*CLK_DIV*DATA_W + CS_HOLD cycles from accept to rx_valid, then one GAP cycle.
// Backpressure: tx_ready is high only in IDLE; a source must hold tx_valid/tx_data until accepted.
//
// Ports:
//   wr_clk, wr_rst_n      system clock, asynchronous active-low reset
//   tx_data/valid/ready   parallel word in, valid/ready handshake
//   rx_data/rx_valid      word sampled from miso, one-cycle valid pulse at end of transfer
//   busy                  high whenever the FSM is not in IDLE
//   sclk, cs_n, mosi      registered SPI outputs (sclk idles low)
//   miso                  SPI data in, assumed synchronous to wr_clk
module spi_master_tx #(
    parameter int DATA_W   = 8,
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              wr_clk,
    input  logic              wr_rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam int CNT_W = 16;
    localparam int BIT_W = $clog2(DATA_W) + 1;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;       // setup / half-period / hold counter, cleared on every phase change
    logic [BIT_W-1:0]  bit_cnt;   // falling edges seen so far in SHIFT
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic              half_done;
    logic              last_bit;

    assign half_done = (cnt == HALF_LAST);
    assign last_bit  = (bit_cnt == BIT_LAST);

    // State register
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // With zero setup time the first half-period starts straight after accept.
                if (tx_valid) state_nxt = (CS_SETUP == 0) ? SHIFT : SETUP;
            end
            SETUP: begin
                if (cnt == SETUP_LAST) state_nxt = SHIFT;
            end
            SHIFT: begin
                // Leave on the DATA_W-th falling edge (sclk currently high, about to drop).
                if (half_done && sclk && last_bit) state_nxt = HOLD;
            end
            HOLD: begin
                if (cnt == HOLD_LAST) state_nxt = GAP;
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Combinational status outputs
    always_comb begin
        tx_ready = (state == IDLE);
        busy     = (state != IDLE);
    end

    // Registered datapath and SPI outputs
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            cnt      <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            sclk     <= 1'b0;
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    sclk    <= 1'b0;
                    if (tx_valid) begin
                        tx_shift <= tx_data;
                        mosi     <= tx_data[DATA_W-1];
                        cs_n     <= 1'b0;
                    end
                end
                SETUP: begin
                    cnt <= (cnt == SETUP_LAST) ? '0 : cnt + CNT_W'(1);
                end
                SHIFT: begin
                    if (half_done) begin
                        cnt  <= '0;
                        sclk <= ~sclk;
                        if (!sclk) begin
                            // Rising edge: first sampled bit ends up in the MSB.
                            rx_shift <= {rx_shift[DATA_W-2:0], miso};
                        end else if (!last_bit) begin
                            // Falling edge: present the next lower bit. The final
                            // falling edge leaves mosi untouched.
                            bit_cnt  <= bit_cnt + BIT_W'(1);
                            tx_shift <= tx_shift << 1;
                            mosi     <= tx_shift[DATA_W-2];
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt      <= '0;
                        cs_n     <= 1'b1;
                        mosi     <= 1'b0;
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    cnt <= '0;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: default 8-bit instance plus a CLK_DIV=1, DATA_W=16 instance.
// Latency: n/a.
// Backpressure: source holds tx_valid until busy shows the word was taken.
module tb_spi_master_tx;

    logic        wr_clk = 1'b0;
    logic        wr_rst_n;

    // Instance A: defaults
    logic [7:0]  tx_data_a;
    logic        tx_valid_a, tx_ready_a, rx_valid_a, busy_a, sclk_a, cs_n_a, mosi_a, miso_a;
    logic [7:0]  rx_data_a;
    logic        loop_a, miso_v_a;

    // Instance B: CLK_DIV=1, DATA_W=16
    logic [15:0] tx_data_b;
    logic        tx_valid_b, tx_ready_b, rx_valid_b, busy_b, sclk_b, cs_n_b, mosi_b, miso_b;
    logic [15:0] rx_data_b;
    logic        loop_b, miso_v_b;

    assign miso_a = loop_a ? mosi_a : miso_v_a;
    assign miso_b = loop_b ? mosi_b : miso_v_b;

    spi_master_tx u_dut_a (
        .wr_clk(wr_clk), .wr_rst_n(wr_rst_n),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .busy(busy_a),
        .sclk(sclk_a), .cs_n(cs_n_a), .mosi(mosi_a), .miso(miso_a)
    );

    spi_master_tx #(.DATA_W(16), .CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2)) u_dut_b (
        .wr_clk(wr_clk), .wr_rst_n(wr_rst_n),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .busy(busy_b),
        .sclk(sclk_b), .cs_n(cs_n_b), .mosi(mosi_b), .miso(miso_b)
    );

    always #5 wr_clk = ~wr_clk;

    wire [1:0]  sclk_v = {sclk_b, sclk_a};
    wire [1:0]  cs_v   = {cs_n_b, cs_n_a};
    wire [1:0]  mosi_v = {mosi_b, mosi_a};
    wire [1:0]  rxv_v  = {rx_valid_b, rx_valid_a};
    wire [1:0]  busy_v = {busy_b, busy_a};
    wire [31:0] rxw0   = {24'd0, rx_data_a};
    wire [31:0] rxw1   = {16'd0, rx_data_b};

    typedef struct packed {
        logic [31:0] mlog;      // mosi captured at every sclk rise, shifted in LSB-side
        logic [31:0] rx;
        int          rises;
        int          cs_low;    // cycles with cs_n low
        int          lat;       // cs_n fall to first sclk rise, in cycles
        int          gap;       // cs_n high cycles before this transfer
        logic        mosi_end;  // mosi in the rx_valid cycle
    } xfer_t;

    xfer_t       xq0[$];
    xfer_t       xq1[$];

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          per_exp[2] = '{4, 2};
    int          rises_cur[2], cs_low[2], hi_run[2], fall_cyc[2], last_rise[2], lat[2], gap[2];
    int          per_err[2], busy_err[2];
    logic [31:0] mlog[2];
    logic        have_rise[2], prev_s[2], prev_c[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Passive monitor, sampled on the falling edge of wr_clk.
    always @(negedge wr_clk) begin
        logic s, c, m, v, b;
        xfer_t r;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            s = sclk_v[k]; c = cs_v[k]; m = mosi_v[k]; v = rxv_v[k]; b = busy_v[k];
            if (!wr_rst_n) begin
                rises_cur[k] = 0; mlog[k] = '0; cs_low[k] = 0; have_rise[k] = 1'b0; hi_run[k] = 0;
            end else begin
                if (s && !prev_s[k]) begin
                    if (have_rise[k] && (cyc - last_rise[k]) != per_exp[k]) per_err[k]++;
                    if (rises_cur[k] == 0) lat[k] = cyc - fall_cyc[k];
                    have_rise[k] = 1'b1;
                    last_rise[k] = cyc;
                    rises_cur[k]++;
                    mlog[k] = {mlog[k][30:0], m};
                end
                if (!c) begin
                    if (prev_c[k]) begin
                        fall_cyc[k] = cyc;
                        gap[k] = hi_run[k];
                    end
                    cs_low[k]++;
                    hi_run[k] = 0;
                end else begin
                    hi_run[k]++;
                end
                if ((!c || v) && !b) busy_err[k]++;
                if (v) begin
                    r.mlog = mlog[k]; r.rx = (k == 0) ? rxw0 : rxw1; r.rises = rises_cur[k];
                    r.cs_low = cs_low[k]; r.lat = lat[k]; r.gap = gap[k]; r.mosi_end = m;
                    if (k == 0) xq0.push_back(r); else xq1.push_back(r);
                    rises_cur[k] = 0; mlog[k] = '0; cs_low[k] = 0; have_rise[k] = 1'b0;
                end
            end
            prev_s[k] = s;
            prev_c[k] = c;
        end
    end

    function automatic int qsize(input int k);
        return (k == 0) ? xq0.size() : xq1.size();
    endfunction

    function automatic xfer_t qget(input int k, input int i);
        xfer_t r;
        r = '0;
        if (k == 0 && i < xq0.size()) r = xq0[i];
        if (k == 1 && i < xq1.size()) r = xq1[i];
        return r;
    endfunction

    // Offer one word and hold it until the DUT leaves IDLE, then scramble tx_data.
    task automatic send(input int k, input logic [31:0] d, input bit lp, input bit mv);
        bit ok = 1'b0;
        if (k == 0) begin tx_data_a = d[7:0];  loop_a = lp; miso_v_a = mv; tx_valid_a = 1'b1; end
        else        begin tx_data_b = d[15:0]; loop_b = lp; miso_v_b = mv; tx_valid_b = 1'b1; end
        for (int t = 0; t < 50; t++) begin
            @(posedge wr_clk); #1;
            if (busy_v[k]) begin ok = 1'b1; break; end
        end
        chk("accept", 32'(ok), 32'd1);
        if (k == 0) begin tx_valid_a = 1'b0; tx_data_a = ~d[7:0];  end
        else        begin tx_valid_b = 1'b0; tx_data_b = ~d[15:0]; end
    endtask

    task automatic wait_x(input int k, input int n);
        bit ok = 1'b0;
        for (int t = 0; t < 600; t++) begin
            @(posedge wr_clk); #1;
            if (qsize(k) >= n) begin ok = 1'b1; break; end
        end
        chk("xfer_timeout", 32'(ok), 32'd1);
        repeat (3) @(posedge wr_clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sclk_a"}, 32'(sclk_a), 0);   chk({tag, "_cs_n_a"}, 32'(cs_n_a), 1);
        chk({tag, "_mosi_a"}, 32'(mosi_a), 0);   chk({tag, "_rdy_a"}, 32'(tx_ready_a), 1);
        chk({tag, "_rxv_a"}, 32'(rx_valid_a), 0); chk({tag, "_rxd_a"}, 32'(rx_data_a), 0);
        chk({tag, "_busy_a"}, 32'(busy_a), 0);
    endtask

    typedef struct {
        logic [7:0] d;
        bit         lp;
        bit         mv;
        logic [7:0] exp_mosi;
        logic [7:0] exp_rx;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vec[5];
        xfer_t r;

        vec[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 8'h00};
        vec[1] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 8'hFF};
        vec[2] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 8'h3C};
        vec[3] = '{8'h00, 1'b1, 1'b0, 8'h00, 8'h00};
        vec[4] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 8'hFF};

        // Reset with random stimulus on the inputs
        wr_rst_n   = 1'b0;
        tx_data_a  = 8'($urandom);  tx_valid_a = 1'b1; loop_a = 1'b0; miso_v_a = 1'($urandom);
        tx_data_b  = 16'($urandom); tx_valid_b = 1'b1; loop_b = 1'b0; miso_v_b = 1'($urandom);
        repeat (3) @(posedge wr_clk);
        #1;
        chk_reset_outputs("rst");
        chk("rst_sclk_b", 32'(sclk_b), 0);  chk("rst_cs_n_b", 32'(cs_n_b), 1);
        chk("rst_mosi_b", 32'(mosi_b), 0);  chk("rst_rdy_b", 32'(tx_ready_b), 1);
        chk("rst_rxd_b", 32'(rx_data_b), 0); chk("rst_busy_b", 32'(busy_b), 0);
        tx_valid_a = 1'b0; tx_valid_b = 1'b0;
        wr_rst_n   = 1'b1;
        repeat (2) @(posedge wr_clk);
        #1;

        // Table-driven single transfers on the default instance
        for (int i = 0; i < 5; i++) begin
            xq0.delete();
            per_err[0] = 0; busy_err[0] = 0;
            send(0, 32'(vec[i].d), vec[i].lp, vec[i].mv);
            wait_x(0, 1);
            r = qget(0, 0);
            chk($sformatf("v%0d_nxfer", i),  32'(qsize(0)), 1);
            chk($sformatf("v%0d_mosi", i),   r.mlog, 32'(vec[i].exp_mosi));
            chk($sformatf("v%0d_rises", i),  32'(r.rises), 8);
            chk($sformatf("v%0d_cslow", i),  32'(r.cs_low), 36);
            chk($sformatf("v%0d_lat", i),    32'(r.lat), 4);
            chk($sformatf("v%0d_rx", i),     r.rx, 32'(vec[i].exp_rx));
            chk($sformatf("v%0d_mosiend", i), 32'(r.mosi_end), 0);
            chk($sformatf("v%0d_period", i), 32'(per_err[0]), 0);
            chk($sformatf("v%0d_busy", i),   32'(busy_err[0]), 0);
            chk($sformatf("v%0d_idle_rdy", i), 32'(tx_ready_a), 1);
        end

        // Back-to-back: 0x81 then 0x7E with tx_valid held between them
        begin
            bit ok;
            xq0.delete();
            loop_a = 1'b1; tx_data_a = 8'h81; tx_valid_a = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 50; t++) begin
                @(posedge wr_clk); #1;
                if (busy_a) begin ok = 1'b1; break; end
            end
            chk("b2b_accept1", 32'(ok), 1);
            tx_data_a = 8'h7E;
            ok = 1'b0;
            for (int t = 0; t < 200; t++) begin
                @(posedge wr_clk); #1;
                if (!busy_a) begin ok = 1'b1; break; end
            end
            chk("b2b_idle", 32'(ok), 1);
            ok = 1'b0;
            for (int t = 0; t < 5; t++) begin
                @(posedge wr_clk); #1;
                if (busy_a) begin ok = 1'b1; break; end
            end
            chk("b2b_accept2", 32'(ok), 1);
            tx_valid_a = 1'b0; tx_data_a = 8'h00;
            wait_x(0, 2);
            chk("b2b_nxfer", 32'(qsize(0)), 2);
            r = qget(0, 0);
            chk("b2b_mosi1", r.mlog, 32'h81);
            chk("b2b_rx1", r.rx, 32'h81);
            r = qget(0, 1);
            chk("b2b_mosi2", r.mlog, 32'h7E);
            chk("b2b_rx2", r.rx, 32'h7E);
            chk("b2b_gap", 32'(r.gap), 2);
            chk("b2b_rises2", 32'(r.rises), 8);
        end

        // Reset after the third sclk rise of 0xF0
        begin
            bit ok = 1'b0;
            xq0.delete();
            send(0, 32'hF0, 1'b0, 1'b0);
            for (int t = 0; t < 200; t++) begin
                @(negedge wr_clk); #1;
                if (rises_cur[0] >= 3) begin ok = 1'b1; break; end
            end
            chk("mid_reach_rise3", 32'(ok), 1);
            chk("mid_sclk_before", 32'(sclk_a), 1);
            wr_rst_n = 1'b0;
            #1;
            chk_reset_outputs("mid");
            repeat (3) @(posedge wr_clk);
            #1;
            wr_rst_n = 1'b1;
            repeat (60) @(posedge wr_clk);
            #1;
            chk("mid_no_rxv", 32'(qsize(0)), 0);
            send(0, 32'h55, 1'b1, 1'b0);
            wait_x(0, 1);
            r = qget(0, 0);
            chk("post_nxfer", 32'(qsize(0)), 1);
            chk("post_mosi", r.mlog, 32'h55);
            chk("post_rx", r.rx, 32'h55);
            chk("post_rises", 32'(r.rises), 8);
        end

        // 16-bit instance, CLK_DIV=1, loopback
        xq1.delete();
        per_err[1] = 0; busy_err[1] = 0;
        send(1, 32'hBEEF, 1'b1, 1'b0);
        wait_x(1, 1);
        r = qget(1, 0);
        chk("w16_nxfer", 32'(qsize(1)), 1);
        chk("w16_mosi", r.mlog, 32'hBEEF);
        chk("w16_rises", 32'(r.rises), 16);
        chk("w16_rx", r.rx, 32'hBEEF);
        chk("w16_lat", 32'(r.lat), 3);
        chk("w16_cslow", 32'(r.cs_low), 36);
        chk("w16_period", 32'(per_err[1]), 0);
        chk("w16_busy", 32'(busy_err[1]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
